// File: rtl/la_cmd_pkg.sv
// Shared types and constants for the logic-analyzer host-command controller.
package la_cmd_pkg;

    typedef enum logic [1:0] {
        OP_RD   = 2'b00,
        OP_WR   = 2'b01,
        OP_DUMP = 2'b10,
        OP_BAD  = 2'b11
    } op_e;

    typedef struct packed {
        op_e        op;
        logic [5:0] addr;
        logic [7:0] data;
    } cmd_t;

    localparam logic [7:0] ACK_BYTE = 8'hA5;
    localparam logic [7:0] NAK_BYTE = 8'hEE;

    localparam logic [5:0] A_TRIG_CFG = 6'h00;
    localparam logic [5:0] A_CH_TRIG1 = 6'h01;
    localparam logic [5:0] A_CH_TRIG2 = 6'h02;
    localparam logic [5:0] A_CH_TRIG3 = 6'h03;
    localparam logic [5:0] A_CH_TRIG4 = 6'h04;
    localparam logic [5:0] A_CH_TRIG5 = 6'h05;
    localparam logic [5:0] A_DECIM    = 6'h06;
    localparam logic [5:0] A_VIH      = 6'h07;
    localparam logic [5:0] A_VIL      = 6'h08;
    localparam logic [5:0] A_MATCH_H  = 6'h09;
    localparam logic [5:0] A_MATCH_L  = 6'h0A;
    localparam logic [5:0] A_MASK_H   = 6'h0B;
    localparam logic [5:0] A_MASK_L   = 6'h0C;
    localparam logic [5:0] A_TPOS_H   = 6'h0D;
    localparam logic [5:0] A_TPOS_L   = 6'h0E;
    localparam logic [5:0] A_LAST     = 6'h0E;

    localparam logic [4:0]  RST_TRIG_LO  = 5'h03;
    localparam logic [4:0]  RST_CH_TRIG  = 5'h01;
    localparam logic [3:0]  RST_DECIM    = 4'h0;
    localparam logic [7:0]  RST_VIH      = 8'hAA;
    localparam logic [7:0]  RST_VIL      = 8'h55;
    localparam logic [15:0] RST_MATCH    = 16'h0000;
    localparam logic [15:0] RST_MASK     = 16'h0000;
    localparam logic [15:0] RST_TRIG_POS = 16'h0001;

endpackage

// File: rtl/la_cfg_regs.sv
// Configuration register file: write decode, read mux, capture_done set/clear.
module la_cfg_regs
    import la_cmd_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [5:0]      addr,
    input  logic [7:0]      wdata,
    input  logic            set_capture_done,
    output logic [7:0]      rdata,
    output logic            addr_valid,
    output logic [5:0]      trig_cfg,
    output logic [5:1][4:0] ch_trig_cfg,
    output logic [3:0]      decimator,
    output logic [7:0]      vih,
    output logic [7:0]      vil,
    output logic [15:0]     match,
    output logic [15:0]     mask,
    output logic [15:0]     trig_pos
);

    logic       cap_done;
    logic [4:0] trig_lo;

    assign trig_cfg   = {cap_done, trig_lo};
    assign addr_valid = (addr <= A_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_done    <= 1'b0;
            trig_lo     <= RST_TRIG_LO;
            ch_trig_cfg <= {5{RST_CH_TRIG}};
            decimator   <= RST_DECIM;
            vih         <= RST_VIH;
            vil         <= RST_VIL;
            match       <= RST_MATCH;
            mask        <= RST_MASK;
            trig_pos    <= RST_TRIG_POS;
        end else begin
            // A capture-complete set outranks a same-cycle clear from a reg-0 write
            if (set_capture_done)
                cap_done <= 1'b1;
            else if (we && addr == A_TRIG_CFG)
                cap_done <= 1'b0;
            if (we) begin
                case (addr)
                    A_TRIG_CFG: trig_lo        <= wdata[4:0];
                    A_DECIM:    decimator      <= wdata[3:0];
                    A_VIH:      vih            <= wdata;
                    A_VIL:      vil            <= wdata;
                    A_MATCH_H:  match[15:8]    <= wdata;
                    A_MATCH_L:  match[7:0]     <= wdata;
                    A_MASK_H:   mask[15:8]     <= wdata;
                    A_MASK_L:   mask[7:0]      <= wdata;
                    A_TPOS_H:   trig_pos[15:8] <= wdata;
                    A_TPOS_L:   trig_pos[7:0]  <= wdata;
                    default: ;
                endcase
                for (int i = 1; i <= 5; i++)
                    if (addr == 6'(i)) ch_trig_cfg[i] <= wdata[4:0];
            end
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (addr)
            A_TRIG_CFG: rdata = {2'b00, trig_cfg};
            A_CH_TRIG1: rdata = {3'b000, ch_trig_cfg[1]};
            A_CH_TRIG2: rdata = {3'b000, ch_trig_cfg[2]};
            A_CH_TRIG3: rdata = {3'b000, ch_trig_cfg[3]};
            A_CH_TRIG4: rdata = {3'b000, ch_trig_cfg[4]};
            A_CH_TRIG5: rdata = {3'b000, ch_trig_cfg[5]};
            A_DECIM:    rdata = {4'h0, decimator};
            A_VIH:      rdata = vih;
            A_VIL:      rdata = vil;
            A_MATCH_H:  rdata = match[15:8];
            A_MATCH_L:  rdata = match[7:0];
            A_MASK_H:   rdata = mask[15:8];
            A_MASK_L:   rdata = mask[7:0];
            A_TPOS_H:   rdata = trig_pos[15:8];
            A_TPOS_L:   rdata = trig_pos[7:0];
            default:    rdata = 8'h00;
        endcase
    end

endmodule

// File: rtl/la_cmd_cfg.sv
// Host-command controller: executes reg read/write commands and streams channel dumps to the UART.
module la_cmd_cfg
    import la_cmd_pkg::*;
#(
    parameter int         ENTRIES = 384,
    parameter int         ADDR_W  = $clog2(ENTRIES),
    parameter logic [7:0] ACK     = ACK_BYTE,
    parameter logic [7:0] NAK     = NAK_BYTE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_rdy,
    input  logic [15:0]       cmd,
    output logic              clr_cmd_rdy,
    output logic              send_resp,
    output logic [7:0]        resp,
    input  logic              resp_sent,
    input  logic              set_capture_done,
    input  logic [ADDR_W-1:0] dump_start,
    output logic [2:0]        dump_chan,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_rdata,
    output logic [5:0]        trig_cfg,
    output logic [5:1][4:0]   ch_trig_cfg,
    output logic [3:0]        decimator,
    output logic [7:0]        vih,
    output logic [7:0]        vil,
    output logic [15:0]       match,
    output logic [15:0]       mask,
    output logic [15:0]       trig_pos
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_TX  = 3'd1;
    localparam logic [2:0] S_DUMP_RD  = 3'd2;
    localparam logic [2:0] S_DUMP_LAT = 3'd3;
    localparam logic [2:0] S_DUMP_TX  = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ENTRIES - 1);

    logic [2:0]        state;
    cmd_t              cmd_q;
    logic              pend;
    logic [ADDR_W-1:0] cnt;
    logic [7:0]        rd_val;
    logic              addr_valid;
    logic              exec;
    logic              reg_we;
    logic              dump_ok;
    logic              tx_done;

    assign exec    = (state == S_IDLE) && pend;
    assign reg_we  = exec && (cmd_q.op == OP_WR) && addr_valid;
    assign dump_ok = (cmd_q.addr[2:0] >= 3'd1) && (cmd_q.addr[2:0] <= 3'd5);
    // resp_sent may still be high from the previous byte during the send_resp cycle
    assign tx_done = resp_sent && !send_resp;

    la_cfg_regs u_regs (
        .clk              (clk),
        .rst_n            (rst_n),
        .we               (reg_we),
        .addr             (cmd_q.addr),
        .wdata            (cmd_q.data),
        .set_capture_done (set_capture_done),
        .rdata            (rd_val),
        .addr_valid       (addr_valid),
        .trig_cfg         (trig_cfg),
        .ch_trig_cfg      (ch_trig_cfg),
        .decimator        (decimator),
        .vih              (vih),
        .vil              (vil),
        .match            (match),
        .mask             (mask),
        .trig_pos         (trig_pos)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cmd_q       <= '0;
            pend        <= 1'b0;
            cnt         <= '0;
            clr_cmd_rdy <= 1'b0;
            send_resp   <= 1'b0;
            resp        <= 8'h00;
            ram_addr    <= '0;
            dump_chan   <= 3'd0;
        end else begin
            clr_cmd_rdy <= 1'b0;
            send_resp   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (exec) begin
                        pend        <= 1'b0;
                        clr_cmd_rdy <= 1'b1;
                        if (cmd_q.op == OP_DUMP && dump_ok) begin
                            ram_addr  <= dump_start;
                            dump_chan <= cmd_q.addr[2:0];
                            cnt       <= '0;
                            state     <= S_DUMP_RD;
                        end else begin
                            send_resp <= 1'b1;
                            state     <= S_WAIT_TX;
                            if (cmd_q.op == OP_RD && addr_valid)
                                resp <= rd_val;
                            else if (cmd_q.op == OP_WR && addr_valid)
                                resp <= ACK;
                            else
                                resp <= NAK;
                        end
                    end else if (cmd_rdy) begin
                        cmd_q <= cmd_t'(cmd);
                        pend  <= 1'b1;
                    end
                end
                S_WAIT_TX: if (tx_done) state <= S_IDLE;
                S_DUMP_RD: state <= S_DUMP_LAT;
                S_DUMP_LAT: begin
                    resp      <= ram_rdata;
                    send_resp <= 1'b1;
                    state     <= S_DUMP_TX;
                end
                S_DUMP_TX: begin
                    if (tx_done) begin
                        if (cnt == LAST_IDX) begin
                            state <= S_IDLE;
                        end else begin
                            cnt      <= cnt + 1'b1;
                            ram_addr <= (ram_addr == LAST_IDX) ? '0 : ram_addr + 1'b1;
                            state    <= S_DUMP_RD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
